// File: rtl/gate_tb_pkg.sv
// Shared types and constants for the gate sweep checker.
package gate_tb_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  // Expected truth tables for 2-input gates; bit k is y for vec == k (vec[1]=a, vec[0]=b).
  localparam logic [3:0] TruthAnd2  = 4'b1000;
  localparam logic [3:0] TruthOr2   = 4'b1110;
  localparam logic [3:0] TruthXor2  = 4'b0110;
  localparam logic [3:0] TruthNand2 = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures the settle window for each vector.
module settle_timer #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int unsigned TimerW = $clog2(HOLD_CYCLES + 1);
  // Loading HOLD_CYCLES-1 and stopping at zero gives exactly HOLD_CYCLES settle cycles.
  localparam logic [TimerW-1:0] LoadVal = TimerW'(HOLD_CYCLES - 1);

  logic [TimerW-1:0] r_cnt;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LoadVal;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TimerW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps every input vector of an N-input gate, samples its output after a settle
// window and scores it against an expected truth table.
module gate_sweep_checker
  import gate_tb_pkg::*;
#(
  parameter int unsigned         N_IN        = 2,
  parameter int unsigned         HOLD_CYCLES = 10,
  parameter logic [2**N_IN-1:0]  TRUTH       = TruthAnd2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic [N_IN-1:0] o_vec,
  input  logic            i_y_in,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_cnt,
  output logic            o_fail_valid,
  output logic [N_IN-1:0] o_fail_idx
);

  state_e          r_state, w_state_nxt;
  logic [N_IN-1:0] r_vec, w_vec_nxt;
  logic [N_IN:0]   r_err_cnt, w_err_cnt_nxt;
  logic            r_fail_valid, w_fail_valid_nxt;
  logic [N_IN-1:0] r_fail_idx, w_fail_idx_nxt;
  logic            w_load;
  logic            w_dec;
  logic            w_zero;
  logic            w_mismatch;

  settle_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_settle_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(w_load),
    .i_dec (w_dec),
    .o_zero(w_zero)
  );

  assign w_mismatch = (i_y_in != TRUTH[r_vec]);

  // State, vector and score registers; reset discards any partial sweep.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_vec        <= '0;
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_vec        <= w_vec_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_fail_valid <= w_fail_valid_nxt;
      r_fail_idx   <= w_fail_idx_nxt;
    end
  end

  // Next-state: start is only honoured from IDLE/DONE; SAMPLE scores and advances.
  always_comb begin
    w_state_nxt      = r_state;
    w_vec_nxt        = r_vec;
    w_err_cnt_nxt    = r_err_cnt;
    w_fail_valid_nxt = r_fail_valid;
    w_fail_idx_nxt   = r_fail_idx;
    w_load           = 1'b0;
    w_dec            = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_nxt      = StSettle;
          w_vec_nxt        = '0;
          w_err_cnt_nxt    = '0;
          w_fail_valid_nxt = 1'b0;
          w_fail_idx_nxt   = '0;
          w_load           = 1'b1;
        end
      end
      StSettle: begin
        if (w_zero) begin
          w_state_nxt = StSample;
        end else begin
          w_dec = 1'b1;
        end
      end
      StSample: begin
        if (w_mismatch) begin
          w_err_cnt_nxt = r_err_cnt + (N_IN + 1)'(1);
          if (!r_fail_valid) begin
            w_fail_valid_nxt = 1'b1;
            w_fail_idx_nxt   = r_vec;
          end
        end
        if (&r_vec) begin
          w_state_nxt = StDone;
        end else begin
          w_vec_nxt   = r_vec + N_IN'(1);
          w_load      = 1'b1;
          w_state_nxt = StSettle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_vec        = r_vec;
  assign o_busy       = (r_state == StSettle) || (r_state == StSample);
  assign o_done       = (r_state == StDone);
  assign o_pass       = (r_state == StDone) && (r_err_cnt == '0);
  assign o_err_cnt    = r_err_cnt;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_idx   = r_fail_idx;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (AND table, OR table, HOLD_CYCLES=1),
// each watching a modelled AND gate with optional stuck-high, per-vector faults and
// settle-window glitches.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  int         sel;
  logic       force_hi;
  logic       glitch;
  logic [3:0] flip_mask;

  logic       start_a, start_o, start_h;
  logic [1:0] vec_a, vec_o, vec_h;
  logic       y_a, y_o, y_h;
  logic       busy_a, busy_o, busy_h;
  logic       done_a, done_o, done_h;
  logic       pass_a, pass_o, pass_h;
  logic [2:0] err_a, err_o, err_h;
  logic       fv_a, fv_o, fv_h;
  logic [1:0] fi_a, fi_o, fi_h;

  logic [1:0] obs_vec;
  logic       obs_busy, obs_done, obs_pass, obs_fv;
  logic [2:0] obs_err;
  logic [1:0] obs_fi;

  int n_checks = 0;
  int n_errors = 0;

  assign start_a = start && (sel == 0);
  assign start_o = start && (sel == 1);
  assign start_h = start && (sel == 2);

  // AND gate under test, with fault injection knobs.
  assign y_a = force_hi | ((vec_a[1] & vec_a[0]) ^ flip_mask[vec_a] ^ glitch);
  assign y_o = force_hi | ((vec_o[1] & vec_o[0]) ^ flip_mask[vec_o] ^ glitch);
  assign y_h = force_hi | ((vec_h[1] & vec_h[0]) ^ flip_mask[vec_h] ^ glitch);

  gate_sweep_checker u_dut_and (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_vec(vec_a), .i_y_in(y_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_err_cnt(err_a),
    .o_fail_valid(fv_a), .o_fail_idx(fi_a)
  );

  gate_sweep_checker #(.N_IN(2), .HOLD_CYCLES(10), .TRUTH(4'b1110)) u_dut_or (
    .i_clk(clk), .i_rst(rst), .i_start(start_o), .o_vec(vec_o), .i_y_in(y_o),
    .o_busy(busy_o), .o_done(done_o), .o_pass(pass_o), .o_err_cnt(err_o),
    .o_fail_valid(fv_o), .o_fail_idx(fi_o)
  );

  gate_sweep_checker #(.N_IN(2), .HOLD_CYCLES(1), .TRUTH(4'b1000)) u_dut_h1 (
    .i_clk(clk), .i_rst(rst), .i_start(start_h), .o_vec(vec_h), .i_y_in(y_h),
    .o_busy(busy_h), .o_done(done_h), .o_pass(pass_h), .o_err_cnt(err_h),
    .o_fail_valid(fv_h), .o_fail_idx(fi_h)
  );

  always_comb begin
    obs_vec = vec_a; obs_busy = busy_a; obs_done = done_a; obs_pass = pass_a;
    obs_err = err_a; obs_fv = fv_a; obs_fi = fi_a;
    case (sel)
      1: begin
        obs_vec = vec_o; obs_busy = busy_o; obs_done = done_o; obs_pass = pass_o;
        obs_err = err_o; obs_fv = fv_o; obs_fi = fi_o;
      end
      2: begin
        obs_vec = vec_h; obs_busy = busy_h; obs_done = done_h; obs_pass = pass_h;
        obs_err = err_h; obs_fv = fv_h; obs_fi = fi_h;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int hold_of(input int s);
    return (s == 2) ? 1 : 10;
  endfunction

  function automatic logic [3:0] truth_of(input int s);
    logic [3:0] t;
    t = (s == 1) ? 4'b1110 : 4'b1000;
    return t;
  endfunction

  // Reference result of a full sweep: compare the gate's output for each vector with
  // the table, count mismatches, remember the lowest failing vector.
  function automatic void expect_sweep(input logic [3:0] truth, input logic [3:0] flips,
                                       input logic hi, output int e, output logic fv,
                                       output int fi);
    logic gy;
    e = 0; fv = 1'b0; fi = 0;
    for (int k = 0; k < 4; k++) begin
      gy = hi | ((k == 3) ^ flips[k]);
      if (gy != truth[k]) begin
        e++;
        if (!fv) begin
          fv = 1'b1;
          fi = k;
        end
      end
    end
  endfunction

  // One full sweep on instance s, checking vec/busy/done every cycle and the score at the end.
  task automatic run_sweep(input string name, input int s, input bit glitches, input bit spam);
    int h, total, e, fi;
    logic fv;
    logic [3:0] want;
    h = hold_of(s);
    total = 4 * (h + 1);
    expect_sweep(truth_of(s), flip_mask, force_hi, e, fv, fi);
    sel = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < total; j++) begin
      want = {1'b1, 1'b0, 2'(j / (h + 1))};
      n_checks++;
      if ({obs_busy, obs_done, obs_vec} !== want) begin
        n_errors++;
        $display("FAIL %s busy/done/vec at offset %0d: got %b want %b", name, j,
                 {obs_busy, obs_done, obs_vec}, want);
      end
      glitch = (glitches && ((j % (h + 1)) != h)) ? 1'($urandom) : 1'b0;
      start = spam ? 1'($urandom) : 1'b0;
      tick();
    end
    glitch = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({obs_busy, obs_done, obs_vec} !== 4'b0111) begin
      n_errors++;
      $display("FAIL %s end busy/done/vec: got %b want 0111", name,
               {obs_busy, obs_done, obs_vec});
    end
    n_checks++;
    if (obs_err !== 3'(e)) begin
      n_errors++;
      $display("FAIL %s err_cnt: got %0d want %0d", name, obs_err, e);
    end
    n_checks++;
    if ({obs_fv, obs_fi} !== {fv, 2'(fi)}) begin
      n_errors++;
      $display("FAIL %s fail_valid/fail_idx: got %b/%0d want %b/%0d", name, obs_fv, obs_fi,
               fv, fi);
    end
    n_checks++;
    if (obs_pass !== (e == 0)) begin
      n_errors++;
      $display("FAIL %s pass: got %b want %b", name, obs_pass, (e == 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 0; force_hi = 1'b0; glitch = 1'b0; flip_mask = 4'h0;
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++;
      if ({obs_busy, obs_done, obs_pass, obs_fv, obs_vec, obs_err, obs_fi} !== 11'b0) begin
        n_errors++;
        $display("FAIL reset_values dut%0d: got %b want 0", s,
                 {obs_busy, obs_done, obs_pass, obs_fv, obs_vec, obs_err, obs_fi});
      end
    end
    rst = 1'b0;
    repeat (2) tick();
    sel = 0;
    #1;
    n_checks++;
    if ({obs_busy, obs_done, obs_vec} !== 4'b0) begin
      n_errors++;
      $display("FAIL idle_no_start: got %b want 0000", {obs_busy, obs_done, obs_vec});
    end
  endtask

  task automatic test_and_sweep();
    run_sweep("and_clean", 0, 1'b0, 1'b0);
  endtask

  task automatic test_or_truth();
    run_sweep("or_vs_and", 1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    flip_mask = 4'b0001;
    sel = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (25) tick();
    n_checks++;
    if ({obs_busy, obs_vec, obs_err} !== {1'b1, 2'd2, 3'd1}) begin
      n_errors++;
      $display("FAIL mid_reset_pre busy/vec/err: got %b want 110001",
               {obs_busy, obs_vec, obs_err});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({obs_busy, obs_done, obs_pass, obs_fv, obs_vec, obs_err, obs_fi} !== 11'b0) begin
      n_errors++;
      $display("FAIL mid_reset_values: got %b want 0",
               {obs_busy, obs_done, obs_pass, obs_fv, obs_vec, obs_err, obs_fi});
    end
    flip_mask = 4'h0;
    run_sweep("after_reset", 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int p;
    logic [4:0] want;
    sel = 2;
    flip_mask = 4'h0;
    start = 1'b1;
    tick();
    // HOLD_CYCLES=1: 8 busy cycles, one DONE cycle, then the held start restarts.
    for (int j = 0; j < 18; j++) begin
      p = j % 9;
      want = {(p < 8), (p == 8), (p == 8), (p < 8) ? 2'(p / 2) : 2'd3};
      n_checks++;
      if ({obs_busy, obs_done, obs_pass, obs_vec} !== want) begin
        n_errors++;
        $display("FAIL back_to_back offset %0d busy/done/pass/vec: got %b want %b", j,
                 {obs_busy, obs_done, obs_pass, obs_vec}, want);
      end
      tick();
    end
    start = 1'b0;
    repeat (8) tick();
    n_checks++;
    if ({obs_busy, obs_done, obs_pass} !== 3'b011) begin
      n_errors++;
      $display("FAIL back_to_back_final busy/done/pass: got %b want 011",
               {obs_busy, obs_done, obs_pass});
    end
  endtask

  task automatic test_start_ignored();
    run_sweep("start_spam", 0, 1'b0, 1'b1);
  endtask

  task automatic test_force_high();
    force_hi = 1'b1;
    run_sweep("y_stuck_high", 0, 1'b0, 1'b0);
    force_hi = 1'b0;
  endtask

  task automatic test_glitch();
    run_sweep("settle_glitch", 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      flip_mask = 4'($urandom);
      force_hi = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 4)) tick();
      run_sweep("random", $urandom_range(0, 2), 1'b1, 1'b1);
    end
    force_hi = 1'b0;
    flip_mask = 4'h0;
  endtask

  initial begin
    test_reset();
    test_and_sweep();
    test_or_truth();
    test_mid_reset();
    test_back_to_back();
    test_start_ignored();
    test_force_high();
    test_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
